// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: one bus port with a one-entry pending register
// and one engine port with burst lock, sharing a single memory port.
module mem_port_arbiter #(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned BUS_WIDTH  = 64,
  parameter  int unsigned ADDR_WIDTH = 16,
  localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter  int unsigned MAX_LOCK   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  bus_read_i,
  input  logic                  bus_write_i,
  input  logic [ADDR_WIDTH-1:0] bus_addr_i,
  input  logic [BUS_WIDTH-1:0]  bus_wdata_i,
  input  logic [MAX_DIM-1:0]    bus_strb_i,
  output logic [BUS_WIDTH-1:0]  bus_rdata_o,
  output logic                  bus_rvalid_o,
  input  logic                  eng_req_i,
  input  logic                  eng_we_i,
  input  logic [ADDR_WIDTH-1:0] eng_addr_i,
  input  logic [BUS_WIDTH-1:0]  eng_wdata_i,
  input  logic [MAX_DIM-1:0]    eng_strb_i,
  input  logic                  eng_lock_i,
  output logic                  eng_gnt_o,
  output logic [BUS_WIDTH-1:0]  eng_rdata_o,
  output logic                  eng_rvalid_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BUS_WIDTH-1:0]  mem_wdata_o,
  output logic [MAX_DIM-1:0]    mem_strb_o,
  input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
  output logic                  mem_busy_o,
  output logic                  ovf_o
);

  localparam int unsigned LOCK_CNT_W = 5;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_BUS  = 2'd1,
    TAG_ENG  = 2'd2
  } rd_tag_e;

  logic                  pend_valid_q;
  logic                  pend_we_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [BUS_WIDTH-1:0]  pend_wdata_q;
  logic [MAX_DIM-1:0]    pend_strb_q;

  logic                  last_eng_q;
  logic                  eng_gnt_q;
  logic [LOCK_CNT_W-1:0] lock_cnt_q;
  logic                  ovf_q;
  rd_tag_e               rd_tag_q;
  logic [BUS_WIDTH-1:0]  bus_rdata_q;

  logic bus_req;
  logic locked;
  logic force_bus;
  logic bus_gnt;
  logic eng_gnt;

  assign bus_req   = bus_read_i | bus_write_i;
  assign locked    = eng_gnt_q & eng_lock_i;
  assign force_bus = locked & pend_valid_q & (lock_cnt_q >= LOCK_CNT_W'(MAX_LOCK));

  // Grant selection: single requester wins outright; contention uses lock, then round-robin
  always_comb begin
    bus_gnt = 1'b0;
    eng_gnt = 1'b0;
    if (pend_valid_q && eng_req_i) begin
      if (locked && !force_bus) begin
        eng_gnt = 1'b1;
      end else if (locked || last_eng_q) begin
        bus_gnt = 1'b1;
      end else begin
        eng_gnt = 1'b1;
      end
    end else if (pend_valid_q) begin
      bus_gnt = 1'b1;
    end else if (eng_req_i) begin
      eng_gnt = 1'b1;
    end
  end

  // Memory port mux; all fields zero when nothing is granted
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    if (bus_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = pend_we_q;
      mem_addr_o  = pend_addr_q;
      mem_wdata_o = pend_wdata_q;
      mem_strb_o  = pend_strb_q;
    end else if (eng_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = eng_we_i;
      mem_addr_o  = eng_addr_i;
      mem_wdata_o = eng_wdata_i;
      mem_strb_o  = eng_strb_i;
    end
  end

  // Pending bus entry: capture when empty or issuing this cycle, else the pulse is dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      pend_strb_q  <= '0;
    end else if (bus_req && (!pend_valid_q || bus_gnt)) begin
      pend_valid_q <= 1'b1;
      pend_we_q    <= bus_write_i;
      pend_addr_q  <= bus_addr_i;
      pend_wdata_q <= bus_wdata_i;
      pend_strb_q  <= bus_strb_i;
    end else if (bus_gnt) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Arbitration history: last winner, engine-granted flag, lock counter, overflow flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_eng_q <= 1'b1;
      eng_gnt_q  <= 1'b0;
      lock_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      eng_gnt_q <= eng_gnt;
      if (bus_gnt) begin
        last_eng_q <= 1'b0;
      end else if (eng_gnt) begin
        last_eng_q <= 1'b1;
      end
      if (!pend_valid_q || !locked || force_bus) begin
        lock_cnt_q <= '0;
      end else if (eng_gnt) begin
        lock_cnt_q <= lock_cnt_q + LOCK_CNT_W'(1);
      end
      if (bus_req && pend_valid_q && !bus_gnt) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Read owner tag for the next-cycle rvalid, and held copy of the last bus read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_tag_q    <= TAG_NONE;
      bus_rdata_q <= '0;
    end else begin
      if (bus_gnt && !pend_we_q) begin
        rd_tag_q <= TAG_BUS;
      end else if (eng_gnt && !eng_we_i) begin
        rd_tag_q <= TAG_ENG;
      end else begin
        rd_tag_q <= TAG_NONE;
      end
      if (rd_tag_q == TAG_BUS) begin
        bus_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign bus_rvalid_o = (rd_tag_q == TAG_BUS);
  assign bus_rdata_o  = (rd_tag_q == TAG_BUS) ? mem_rdata_i : bus_rdata_q;
  assign eng_rvalid_o = (rd_tag_q == TAG_ENG);
  assign eng_rdata_o  = mem_rdata_i;
  assign eng_gnt_o    = eng_gnt;
  assign mem_busy_o   = pend_valid_q | (eng_lock_i & eng_req_i);
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change just after the falling
// edge and outputs are sampled 1ns later, mid-cycle.
module tb_mem_port_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 64;
  localparam int unsigned AW = 16;
  localparam int unsigned SW = BW / DW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          bus_read_i, bus_write_i;
  logic [AW-1:0] bus_addr_i;
  logic [BW-1:0] bus_wdata_i;
  logic [SW-1:0] bus_strb_i;
  logic [BW-1:0] bus_rdata_o;
  logic          bus_rvalid_o;
  logic          eng_req_i, eng_we_i, eng_lock_i;
  logic [AW-1:0] eng_addr_i;
  logic [BW-1:0] eng_wdata_i;
  logic [SW-1:0] eng_strb_i;
  logic          eng_gnt_o;
  logic [BW-1:0] eng_rdata_o;
  logic          eng_rvalid_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_wdata_o;
  logic [SW-1:0] mem_strb_o;
  logic [BW-1:0] mem_rdata_i;
  logic          mem_busy_o, ovf_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_port_arbiter #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_LOCK(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .bus_read_i(bus_read_i), .bus_write_i(bus_write_i), .bus_addr_i(bus_addr_i),
    .bus_wdata_i(bus_wdata_i), .bus_strb_i(bus_strb_i),
    .bus_rdata_o(bus_rdata_o), .bus_rvalid_o(bus_rvalid_o),
    .eng_req_i(eng_req_i), .eng_we_i(eng_we_i), .eng_addr_i(eng_addr_i),
    .eng_wdata_i(eng_wdata_i), .eng_strb_i(eng_strb_i), .eng_lock_i(eng_lock_i),
    .eng_gnt_o(eng_gnt_o), .eng_rdata_o(eng_rdata_o), .eng_rvalid_o(eng_rvalid_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_rdata_i(mem_rdata_i),
    .mem_busy_o(mem_busy_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    bus_read_i = 1'b0; bus_write_i = 1'b0; bus_addr_i = '0; bus_wdata_i = '0; bus_strb_i = '0;
    eng_req_i = 1'b0; eng_we_i = 1'b0; eng_addr_i = '0; eng_wdata_i = '0; eng_strb_i = '0;
    eng_lock_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    mem_rdata_i = 64'h1122334455667788;
    @(negedge clk_i); #1;
    vec_cnt++; if (mem_en_o !== 1'b0) begin err_cnt++; $display("FAIL rst_mem_en: got %b want 0", mem_en_o); end
    vec_cnt++; if (eng_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL rst_eng_gnt: got %b want 0", eng_gnt_o); end
    vec_cnt++; if ({bus_rvalid_o, eng_rvalid_o, ovf_o, mem_busy_o} !== 4'b0) begin err_cnt++; $display("FAIL rst_flags: got %b want 0000", {bus_rvalid_o, eng_rvalid_o, ovf_o, mem_busy_o}); end
    vec_cnt++; if (bus_rdata_o !== 64'h0) begin err_cnt++; $display("FAIL rst_bus_rdata: got %h want 0", bus_rdata_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_bus_read();
    do_reset();
    mem_rdata_i = 64'h1122334455667788;
    @(negedge clk_i); bus_read_i = 1'b1; bus_addr_i = 16'h0010; #1;
    vec_cnt++; if (mem_en_o !== 1'b0) begin err_cnt++; $display("FAIL rd_pulse_cycle_en: got %b want 0", mem_en_o); end
    @(negedge clk_i); bus_read_i = 1'b0; bus_addr_i = '0; #1;
    vec_cnt++; if ({mem_en_o, mem_we_o} !== 2'b10) begin err_cnt++; $display("FAIL rd_issue_en_we: got %b want 10", {mem_en_o, mem_we_o}); end
    vec_cnt++; if (mem_addr_o !== 16'h0010) begin err_cnt++; $display("FAIL rd_issue_addr: got %h want 0010", mem_addr_o); end
    vec_cnt++; if (bus_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL rd_early_rvalid: got %b want 0", bus_rvalid_o); end
    @(negedge clk_i); #1;
    vec_cnt++; if (bus_rvalid_o !== 1'b1) begin err_cnt++; $display("FAIL rd_rvalid: got %b want 1", bus_rvalid_o); end
    vec_cnt++; if (bus_rdata_o !== 64'h1122334455667788) begin err_cnt++; $display("FAIL rd_rdata: got %h want 1122334455667788", bus_rdata_o); end
    vec_cnt++; if (mem_en_o !== 1'b0) begin err_cnt++; $display("FAIL rd_after_en: got %b want 0", mem_en_o); end
    @(negedge clk_i); mem_rdata_i = 64'hDEADBEEFCAFEF00D; #1;
    vec_cnt++; if (bus_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL rd_rvalid_pulse: got %b want 0", bus_rvalid_o); end
    vec_cnt++; if (bus_rdata_o !== 64'h1122334455667788) begin err_cnt++; $display("FAIL rd_rdata_hold: got %h want 1122334455667788", bus_rdata_o); end
  endtask

  task automatic test_eng_read();
    do_reset();
    mem_rdata_i = 64'hA5A5A5A55A5A5A5A;
    @(negedge clk_i); eng_req_i = 1'b1; eng_we_i = 1'b0; eng_addr_i = 16'h0080; eng_strb_i = 4'h3; #1;
    vec_cnt++; if ({eng_gnt_o, mem_en_o, mem_we_o} !== 3'b110) begin err_cnt++; $display("FAIL er_grant: got %b want 110", {eng_gnt_o, mem_en_o, mem_we_o}); end
    vec_cnt++; if ({mem_addr_o, mem_strb_o} !== {16'h0080, 4'h3}) begin err_cnt++; $display("FAIL er_fields: got %h want 00803", {mem_addr_o, mem_strb_o}); end
    vec_cnt++; if (mem_busy_o !== 1'b0) begin err_cnt++; $display("FAIL er_busy_unlocked: got %b want 0", mem_busy_o); end
    @(negedge clk_i); eng_req_i = 1'b0; #1;
    vec_cnt++; if ({eng_rvalid_o, bus_rvalid_o} !== 2'b10) begin err_cnt++; $display("FAIL er_rvalid: got %b want 10", {eng_rvalid_o, bus_rvalid_o}); end
    vec_cnt++; if (eng_rdata_o !== 64'hA5A5A5A55A5A5A5A) begin err_cnt++; $display("FAIL er_rdata: got %h want a5a5a5a55a5a5a5a", eng_rdata_o); end
    @(negedge clk_i); #1;
    vec_cnt++; if (eng_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL er_rvalid_pulse: got %b want 0", eng_rvalid_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    // c: bus write A
    @(negedge clk_i); bus_write_i = 1'b1; bus_addr_i = 16'h0020; bus_wdata_i = 64'hAAAA; bus_strb_i = 4'hF;
    // c+1: pending A and engine both request, last winner engine -> bus; second bus write B captured
    @(negedge clk_i); bus_addr_i = 16'h0021; bus_wdata_i = 64'hBBBB; bus_strb_i = 4'h1;
    eng_req_i = 1'b1; eng_we_i = 1'b1; eng_addr_i = 16'h0030; eng_wdata_i = 64'hEEEE; eng_strb_i = 4'hC; #1;
    vec_cnt++; if ({mem_en_o, mem_we_o, eng_gnt_o} !== 3'b110) begin err_cnt++; $display("FAIL rr1_bus_wins: got %b want 110", {mem_en_o, mem_we_o, eng_gnt_o}); end
    vec_cnt++; if ({mem_addr_o, mem_wdata_o} !== {16'h0020, 64'hAAAA}) begin err_cnt++; $display("FAIL rr1_fields: got %h want 0020 000000000000aaaa", {mem_addr_o, mem_wdata_o}); end
    vec_cnt++; if (mem_busy_o !== 1'b1) begin err_cnt++; $display("FAIL rr1_busy: got %b want 1", mem_busy_o); end
    // c+2: pending B and engine, last winner bus -> engine
    @(negedge clk_i); bus_write_i = 1'b0; #1;
    vec_cnt++; if ({eng_gnt_o, mem_addr_o, mem_strb_o} !== {1'b1, 16'h0030, 4'hC}) begin err_cnt++; $display("FAIL rr2_eng_wins: got %h want 10030c", {eng_gnt_o, mem_addr_o, mem_strb_o}); end
    // c+3: last winner engine, no lock -> bus B
    @(negedge clk_i); #1;
    vec_cnt++; if ({eng_gnt_o, mem_addr_o, mem_strb_o} !== {1'b0, 16'h0021, 4'h1}) begin err_cnt++; $display("FAIL rr3_bus_wins: got %h want 00211", {eng_gnt_o, mem_addr_o, mem_strb_o}); end
    // c+4: nothing pending -> engine
    @(negedge clk_i); #1;
    vec_cnt++; if (eng_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL rr4_eng_only: got %b want 1", eng_gnt_o); end
    vec_cnt++; if (ovf_o !== 1'b0) begin err_cnt++; $display("FAIL rr_no_ovf: got %b want 0", ovf_o); end
    eng_req_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk_i); bus_write_i = 1'b1; bus_addr_i = 16'h0070; bus_wdata_i = 64'h0101; bus_strb_i = 4'h5;
    @(negedge clk_i); bus_addr_i = 16'h0071; bus_wdata_i = 64'h0202; bus_strb_i = 4'hA; #1;
    vec_cnt++; if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o} !== {2'b11, 16'h0070, 64'h0101, 4'h5}) begin err_cnt++; $display("FAIL b2b_first: got %h want first write", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o}); end
    @(negedge clk_i); bus_write_i = 1'b0; #1;
    vec_cnt++; if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o} !== {2'b11, 16'h0071, 64'h0202, 4'hA}) begin err_cnt++; $display("FAIL b2b_second: got %h want second write", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o}); end
    @(negedge clk_i); #1;
    vec_cnt++; if ({mem_en_o, ovf_o, mem_busy_o} !== 3'b000) begin err_cnt++; $display("FAIL b2b_done: got %b want 000", {mem_en_o, ovf_o, mem_busy_o}); end
  endtask

  // Engine locked for 20 cycles; a bus write pulses in cycle 0 (and optionally a
  // second one in cycle 3). The pending write must win at cycle 17, after 16
  // locked engine grants in cycles 1..16.
  task automatic run_lock(input bit second, input string tag);
    int bus_grants;
    int bus_cycle;
    int eng_waiting;
    bit second_seen;
    logic [AW+BW+SW-1:0] bus_fields;
    bus_grants = 0; bus_cycle = -1; eng_waiting = 0; second_seen = 1'b0; bus_fields = '0;
    do_reset();
    for (int e = 0; e < 20; e++) begin
      @(negedge clk_i);
      eng_req_i = 1'b1; eng_lock_i = 1'b1; eng_we_i = 1'b1; eng_addr_i = 16'h0040;
      eng_wdata_i = 64'h4444; eng_strb_i = 4'hF;
      bus_write_i = 1'b0; bus_addr_i = '0; bus_wdata_i = '0; bus_strb_i = '0;
      if (e == 0) begin bus_write_i = 1'b1; bus_addr_i = 16'h0050; bus_wdata_i = 64'h5555; bus_strb_i = 4'h6; end
      if (second && e == 3) begin bus_write_i = 1'b1; bus_addr_i = 16'h0060; bus_wdata_i = 64'h6666; bus_strb_i = 4'h9; end
      #1;
      vec_cnt++; if (mem_busy_o !== 1'b1) begin err_cnt++; $display("FAIL %s_busy c%0d: got %b want 1", tag, e, mem_busy_o); end
      if (mem_en_o && !eng_gnt_o) begin
        bus_grants++; bus_cycle = e; bus_fields = {mem_addr_o, mem_wdata_o, mem_strb_o};
      end
      if (mem_en_o && !eng_gnt_o && e < 17) eng_waiting = -100;
      if (eng_gnt_o && e >= 1 && e <= 16) eng_waiting++;
      if (mem_en_o && mem_addr_o == 16'h0060) second_seen = 1'b1;
      if (second && e == 3) begin
        vec_cnt++; if (ovf_o !== 1'b0) begin err_cnt++; $display("FAIL %s_ovf_early: got %b want 0", tag, ovf_o); end
      end
    end
    @(negedge clk_i); idle_inputs(); #1;
    if (mem_en_o && mem_addr_o == 16'h0060) second_seen = 1'b1;
    vec_cnt++; if (bus_grants !== 1) begin err_cnt++; $display("FAIL %s_bus_grants: got %0d want 1", tag, bus_grants); end
    vec_cnt++; if (bus_cycle !== 17) begin err_cnt++; $display("FAIL %s_bus_cycle: got %0d want 17", tag, bus_cycle); end
    vec_cnt++; if (eng_waiting !== 16) begin err_cnt++; $display("FAIL %s_locked_grants: got %0d want 16", tag, eng_waiting); end
    vec_cnt++; if (bus_fields !== {16'h0050, 64'h5555, 4'h6}) begin err_cnt++; $display("FAIL %s_bus_fields: got %h want first write", tag, bus_fields); end
    vec_cnt++; if (second_seen !== 1'b0) begin err_cnt++; $display("FAIL %s_dropped_seen: got %b want 0", tag, second_seen); end
    vec_cnt++; if (ovf_o !== second) begin err_cnt++; $display("FAIL %s_ovf: got %b want %b", tag, ovf_o, second); end
  endtask

  task automatic test_lock();
    run_lock(1'b0, "lock");
  endtask

  task automatic test_overflow();
    run_lock(1'b1, "ovf");
    @(negedge clk_i); #1;
    vec_cnt++; if (ovf_o !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b want 1", ovf_o); end
  endtask

  // Engine read issues, then reset drops before the edge that would load the tag
  task automatic test_reset_inflight();
    mem_rdata_i = 64'h0F0F0F0F0F0F0F0F;
    @(negedge clk_i); eng_req_i = 1'b1; eng_we_i = 1'b0; eng_addr_i = 16'h0090; #1;
    vec_cnt++; if (eng_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL ri_grant: got %b want 1", eng_gnt_o); end
    #3 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    vec_cnt++; if (eng_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL ri_rvalid_edge: got %b want 0", eng_rvalid_o); end
    idle_inputs();
    @(negedge clk_i); #1;
    vec_cnt++; if ({eng_rvalid_o, bus_rvalid_o, ovf_o, mem_busy_o, mem_en_o, eng_gnt_o} !== 6'b0) begin err_cnt++; $display("FAIL ri_in_reset: got %b want 000000", {eng_rvalid_o, bus_rvalid_o, ovf_o, mem_busy_o, mem_en_o, eng_gnt_o}); end
    vec_cnt++; if ({bus_rdata_o, mem_addr_o, mem_wdata_o, mem_strb_o} !== '0) begin err_cnt++; $display("FAIL ri_in_reset_data: got %h want 0", {bus_rdata_o, mem_addr_o, mem_wdata_o, mem_strb_o}); end
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
    vec_cnt++; if ({eng_rvalid_o, bus_rvalid_o, ovf_o, mem_busy_o, mem_en_o, eng_gnt_o} !== 6'b0) begin err_cnt++; $display("FAIL ri_after_reset: got %b want 000000", {eng_rvalid_o, bus_rvalid_o, ovf_o, mem_busy_o, mem_en_o, eng_gnt_o}); end
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    mem_rdata_i = '0;
    test_reset();
    test_bus_read();
    test_eng_read();
    test_round_robin();
    test_back_to_back();
    test_lock();
    test_overflow();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
